// File: rtl/morse_symbol_timer.sv
// Morse key timing front end: classifies presses as dot/dash, detects character
// and word gaps, and packs symbols MSB-first into a 5-bit code with a length.
module morse_symbol_timer #(
  parameter int DASH_TICK_COUNT           = 30_000_000,
  parameter int ILLEGAL_SYMBOL_TICK_COUNT = 100_000_000,
  parameter int CHAR_TICK_COUNT           = 175_000_000,
  parameter int WORD_TICK_COUNT           = 250_000_000,
  parameter int CNT_W                     = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_i,
  output logic       sym_valid_o,
  output logic       sym_o,
  output logic       char_valid_o,
  output logic [4:0] char_code_o,
  output logic [2:0] char_len_o,
  output logic       word_end_o,
  output logic       illegal_o,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] L_DASH    = CNT_W'(DASH_TICK_COUNT);
  localparam logic [CNT_W-1:0] L_ILLEGAL = CNT_W'(ILLEGAL_SYMBOL_TICK_COUNT);
  localparam logic [CNT_W-1:0] L_CHAR    = CNT_W'(CHAR_TICK_COUNT);
  localparam logic [CNT_W-1:0] L_WORD    = CNT_W'(WORD_TICK_COUNT);
  localparam logic [CNT_W-1:0] L_ONE     = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_press_cnt;
  logic [CNT_W-1:0] r_gap_cnt;
  logic [4:0]       r_acc_code;
  logic [2:0]       r_acc_len;
  logic             r_sym_valid;
  logic             r_sym;
  logic             r_char_valid;
  logic [4:0]       r_char_code;
  logic [2:0]       r_char_len;
  logic             r_word_end;
  logic             r_illegal;

  logic [CNT_W-1:0] w_press_inc;
  logic [CNT_W-1:0] w_gap_inc;
  logic             w_sym;
  logic [4:0]       w_new_code;

  // Counters hold at all-ones rather than wrapping.
  assign w_press_inc = (r_press_cnt == '1) ? r_press_cnt : r_press_cnt + L_ONE;
  assign w_gap_inc   = (r_gap_cnt == '1) ? r_gap_cnt : r_gap_cnt + L_ONE;
  assign w_sym       = (r_press_cnt >= L_DASH);

  always_comb begin
    w_new_code = r_acc_code;
    case (r_acc_len)
      3'd0:    w_new_code[4] = w_sym;
      3'd1:    w_new_code[3] = w_sym;
      3'd2:    w_new_code[2] = w_sym;
      3'd3:    w_new_code[1] = w_sym;
      3'd4:    w_new_code[0] = w_sym;
      default: w_new_code = r_acc_code;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_press_cnt  <= '0;
      r_gap_cnt    <= '0;
      r_acc_code   <= '0;
      r_acc_len    <= '0;
      r_sym_valid  <= 1'b0;
      r_sym        <= 1'b0;
      r_char_valid <= 1'b0;
      r_char_code  <= '0;
      r_char_len   <= '0;
      r_word_end   <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_sym_valid  <= 1'b0;
      r_sym        <= 1'b0;
      r_char_valid <= 1'b0;
      r_word_end   <= 1'b0;
      r_illegal    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (btn_i) begin
            r_press_cnt <= L_ONE;
            r_state     <= S_PRESS;
          end
        end
        S_PRESS: begin
          if (btn_i) begin
            r_press_cnt <= w_press_inc;
            if (w_press_inc == L_ILLEGAL) begin
              r_illegal  <= 1'b1;
              r_acc_code <= '0;
              r_acc_len  <= '0;
              r_state    <= S_ERR;
            end
          end else if (r_acc_len < 3'd5) begin
            r_acc_code  <= w_new_code;
            r_acc_len   <= r_acc_len + 3'd1;
            r_sym_valid <= 1'b1;
            r_sym       <= w_sym;
            r_gap_cnt   <= L_ONE;
            r_state     <= S_GAP;
          end else begin
            // A sixth symbol cannot be represented; drop the whole character.
            r_illegal  <= 1'b1;
            r_acc_code <= '0;
            r_acc_len  <= '0;
            r_state    <= S_IDLE;
          end
        end
        S_GAP: begin
          if (btn_i) begin
            r_press_cnt <= L_ONE;
            r_state     <= S_PRESS;
          end else begin
            r_gap_cnt <= w_gap_inc;
            if (w_gap_inc == L_CHAR && r_acc_len != 3'd0) begin
              r_char_valid <= 1'b1;
              r_char_code  <= r_acc_code;
              r_char_len   <= r_acc_len;
              r_acc_code   <= '0;
              r_acc_len    <= '0;
            end
            if (w_gap_inc == L_WORD) begin
              r_word_end <= 1'b1;
              r_state    <= S_IDLE;
            end
          end
        end
        S_ERR: begin
          if (!btn_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sym_valid_o  = r_sym_valid;
  assign sym_o        = r_sym;
  assign char_valid_o = r_char_valid;
  assign char_code_o  = r_char_code;
  assign char_len_o   = r_char_len;
  assign word_end_o   = r_word_end;
  assign illegal_o    = r_illegal;
  assign dbg_state_o  = r_state;

endmodule
